// File: rtl/gpio_in_fifo_if.sv
// gpio_in_fifo_if: CPU byte-bus signals between the bus master and the input peripheral
interface gpio_in_fifo_if #(
  parameter int size_addr = 3
);
  logic [size_addr-1:0] address;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic read;
  logic write;
  logic ready_r;
  logic ready_w;
  modport master (output address, data_in, read, write, input data_out, ready_r, ready_w);
  modport slave (input address, data_in, read, write, output data_out, ready_r, ready_w);
endinterface

// File: rtl/gpio_in_fifo.sv
// gpio_in_fifo: multi-channel byte input peripheral with per-channel FIFOs popped over the CPU bus
module gpio_in_fifo #(
  parameter int size_addr = 3,
  parameter int size = 2,
  parameter int depth_log = 2
) (
  input  logic clk,
  input  logic reset,
  gpio_in_fifo_if.slave bus,
  input  logic [size-1:0] port_write,
  input  logic [size*8-1:0] port_in,
  output logic [size-1:0] nonempty
);
  localparam int depth = 2 ** depth_log;
  localparam int cw = size > 1 ? $clog2(size) : 1;
  localparam int nw = depth_log + 1;
  logic [size_addr-1:0] addr;
  int unsigned a;
  logic [7:0] mem_q [size][depth];
  logic [depth_log-1:0] wp_q [size];
  logic [depth_log-1:0] wp_d [size];
  logic [depth_log-1:0] rp_q [size];
  logic [depth_log-1:0] rp_d [size];
  logic [nw-1:0] cnt_q [size];
  logic [nw-1:0] cnt_d [size];
  logic [size-1:0] ovf_q, ovf_d, push, pop, ne_q, ne_d;
  logic pend_q, pend_d, rdy_r_q, rdy_r_d, rdy_w_q;
  logic [cw-1:0] pch_q, pch_d;
  logic [7:0] dout_q, dout_d;
  assign addr = bus.address;
  assign a = 32'(addr);
  assign bus.data_out = dout_q;
  assign bus.ready_r = rdy_r_q;
  assign bus.ready_w = rdy_w_q;
  assign nonempty = ne_q;
  always_comb begin
    pend_d = pend_q;
    pch_d = pch_q;
    rdy_r_d = 1'b0;
    dout_d = dout_q;
    pop = '0;
    if (bus.read) begin
      pend_d = 1'b0;
      rdy_r_d = 1'b1;
      dout_d = 8'h00;
      for (int i = 0; i < size; i++) begin
        if (a == i && cnt_q[i] != '0) begin
          pop[i] = 1'b1;
          dout_d = mem_q[i][rp_q[i]];
        end else if (a == i) begin
          pend_d = 1'b1;
          pch_d = cw'(i);
          rdy_r_d = 1'b0;
          dout_d = dout_q;
        end
        if (a == i + size) dout_d = {5'(cnt_q[i]), ovf_q[i], cnt_q[i] == nw'(depth), cnt_q[i] != '0};
      end
    end else if (pend_q) begin
      for (int i = 0; i < size; i++) begin
        if (32'(pch_q) == i && cnt_q[i] != '0) begin
          pop[i] = 1'b1;
          pend_d = 1'b0;
          rdy_r_d = 1'b1;
          dout_d = mem_q[i][rp_q[i]];
        end
      end
    end
    for (int i = 0; i < size; i++) begin
      push[i] = port_write[i] && (cnt_q[i] != nw'(depth) || pop[i]);
      ovf_d[i] = (port_write[i] && !push[i]) || (ovf_q[i] && !(bus.write && a == i + size && bus.data_in[2]));
      cnt_d[i] = cnt_q[i] + nw'(push[i]) - nw'(pop[i]);
      wp_d[i] = wp_q[i] + depth_log'(push[i]);
      rp_d[i] = rp_q[i] + depth_log'(pop[i]);
      ne_d[i] = cnt_d[i] != '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= 1'b0;
      pch_q <= '0;
      rdy_r_q <= 1'b0;
      rdy_w_q <= 1'b0;
      dout_q <= 8'h00;
      ovf_q <= '0;
      ne_q <= '0;
      for (int i = 0; i < size; i++) begin
        wp_q[i] <= '0;
        rp_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      pch_q <= pch_d;
      rdy_r_q <= rdy_r_d;
      rdy_w_q <= bus.write;
      dout_q <= dout_d;
      ovf_q <= ovf_d;
      ne_q <= ne_d;
      for (int i = 0; i < size; i++) begin
        wp_q[i] <= wp_d[i];
        rp_q[i] <= rp_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < size; i++) if (push[i] && !reset) mem_q[i][wp_q[i]] <= port_in[i*8 +: 8];
  end
endmodule

// File: tb/tb_gpio_in_fifo.sv
// tb_gpio_in_fifo: scoreboard bench for gpio_in_fifo with directed bus and port stimulus
module tb_gpio_in_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] port_write = '0;
  logic [15:0] port_in = '0;
  logic [1:0] nonempty;
  logic [7:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  gpio_in_fifo_if #(.size_addr(3)) bus ();
  gpio_in_fifo #(.size_addr(3), .size(2), .depth_log(2)) dut (
    .clk(clk), .reset(reset), .bus(bus), .port_write(port_write), .port_in(port_in), .nonempty(nonempty)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rd_stall(input logic [2:0] adr);
    bus.address = adr;
    bus.read = 1'b1;
    tick();
    bus.read = 1'b0;
  endtask
  task automatic rd(input logic [2:0] adr, input logic [7:0] e);
    exp_q.push_back(e);
    rd_stall(adr);
  endtask
  task automatic wr(input logic [2:0] adr, input logic [7:0] d);
    bus.address = adr;
    bus.data_in = d;
    bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
    chk("ready_w", 8'(bus.ready_w), 8'h01);
  endtask
  task automatic push(input int ch, input logic [7:0] b);
    port_write[ch] = 1'b1;
    port_in[ch*8 +: 8] = b;
    tick();
    port_write = '0;
  endtask
  initial begin
    bus.address = '0;
    bus.data_in = '0;
    bus.read = 1'b0;
    bus.write = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (bus.ready_r === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ready_r: unexpected completion with data_out %h, no read outstanding", bus.data_out);
          end else chk("data_out", bus.data_out, exp_q.pop_front());
        end
      end
    join_none
    repeat (2) tick();
    reset = 1'b0;
    chk("reset nonempty", 8'(nonempty), 8'h00);
    chk("reset data_out", bus.data_out, 8'h00);
    chk("reset ready_r", 8'(bus.ready_r), 8'h00);
    rd(2, 8'h00);
    rd(5, 8'h00);
    push(0, 8'hA1);
    chk("nonempty after push", 8'(nonempty), 8'h01);
    push(0, 8'hA2);
    rd(0, 8'hA1);
    rd(0, 8'hA2);
    rd(2, 8'h00);
    rd_stall(1);
    repeat (5) tick();
    push(1, 8'h5C);
    exp_q.push_back(8'h5C);
    chk("stall early ready_r", 8'(bus.ready_r), 8'h00);
    tick();
    chk("stall ready_r", 8'(bus.ready_r), 8'h01);
    tick();
    for (int i = 1; i <= 5; i++) push(0, 8'(i));
    rd(2, 8'h27);
    for (int i = 1; i <= 4; i++) rd(0, 8'(i));
    wr(2, 8'h04);
    rd(2, 8'h00);
    for (int i = 0; i < 4; i++) push(0, 8'h10 + 8'(i));
    bus.address = 3'd0;
    bus.read = 1'b1;
    port_write[0] = 1'b1;
    port_in[7:0] = 8'hEE;
    exp_q.push_back(8'h10);
    tick();
    bus.read = 1'b0;
    port_write = '0;
    rd(2, 8'h23);
    rd(0, 8'h11);
    rd(0, 8'h12);
    rd(0, 8'h13);
    rd(0, 8'hEE);
    rd(2, 8'h00);
    rd_stall(1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push(1, 8'h77);
    repeat (3) tick();
    chk("nonempty after reset", 8'(nonempty), 8'h02);
    rd(3, 8'h09);
    rd(1, 8'h77);
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d completions outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpio_in_fifo.md
Name: gpio_in_fifo

Overview:
- Multi-channel general-purpose input peripheral on the CPU byte bus.
- Each of `size` external byte ports pushes into its own FIFO of depth 2^depth_log.
- CPU pops bytes through per-channel data addresses and reads/clears per-channel status.
- A read of an empty channel stalls (ready_r held low) until the port delivers a byte.

Parameters:
- size_addr, 3: bus address width; must satisfy 2^size_addr >= 2*size.
- size, 2: number of input channels (1..8).
- depth_log, 2: log2 of per-channel FIFO depth (1..4; depth 2..16).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  size_addr  bus address.
- data_in  input  8  bus write data.
- data_out  output  8  bus read data, registered.
- read  input  1  bus read strobe, one-cycle pulse.
- write  input  1  bus write strobe, one-cycle pulse.
- ready_r  output  1  read-complete pulse.
- ready_w  output  1  write-complete pulse.
- port_write  input  size  per-channel push strobe.
- port_in  input  size*8  channel i byte at [i*8+7 -: 8].
- nonempty  output  size  per-channel FIFO-not-empty flags, registered.

Behaviour:
- Reset: all FIFOs empty (ptrs/counts 0); overflow flags 0; pending read cleared; ready_r=0, ready_w=0, data_out=8'h00, nonempty=0. Reset mid-stall abandons the read; no ready_r is issued for it.
- Address map:
  - A < size: data channel A (pop).
  - size <= A < 2*size: status channel A-size.
  - Otherwise: unmapped.
- Status byte:
  - bit0 = nonempty.
  - bit1 = full.
  - bit2 = overflow (sticky).
  - bits7:3 = count (0..16).
- Push: port_write[i] at edge pushes port_in byte i.
  - If the FIFO is full and there is no same-edge pop, the byte is dropped and overflow[i] is set.
  - If the FIFO is full with a same-edge pop, the push is accepted.
  - Pointers wrap modulo depth.
- Data read, FIFO non-empty at the read edge: next cycle ready_r=1 for exactly one cycle, data_out = head byte, head popped at that same edge.
- Data read, FIFO empty: the read becomes pending (channel latched).
  - Each cycle, the pending channel is checked; when count>0 at an edge, the pop is performed and ready_r=1 / data_out set in the following cycle.
  - A byte pushed at edge M gives ready_r high in cycle M+1 to M+2 (one cycle after the push becomes visible).
- Status read: next cycle ready_r=1, data_out = status sampled at the read edge. Never stalls; never pops.
- Unmapped read: next cycle ready_r=1, data_out=8'h00.
- Writes: ready_w <= write (one-cycle pulse, every address).
  - Write to a status address clears the channel's overflow when data_in[2]=1.
  - Writes to data or unmapped addresses have no effect.
  - If a clear and a new overflow occur on the same edge, set wins.
- A new read while pending replaces the pending read (old one never completes).
- data_out holds its value between completions.
- Simultaneous push and pop on one channel: both occur, count unchanged, FIFO order preserved.
- nonempty[i] <= (next count != 0), updated every cycle.

Test Plan:
- Reset, then read status ch0 (addr 2) -> ready_r next cycle; data_out=8'h00; nonempty=2'b00.
- Push 8'hA1, 8'hA2 on ch0 (back-to-back); read addr 0 twice -> data_out 8'hA1 then 8'hA2, each with a one-cycle ready_r; status afterwards 8'h00.
- Read addr 1 with ch1 empty; hold idle 5 cycles (ready_r stays 0); push 8'h5C on ch1 at edge M -> ready_r=1 in cycle M+1..M+2, data_out=8'h5C.
- Push 5 bytes 8'h01..8'h05 into ch0 (depth 4) -> status addr 2 = 8'h27 (count 4, overflow, full, nonempty); pops return 01..04. Then write addr 2 data 8'h04 -> status = 8'h00.
- With ch0 full, pop and push 8'hEE on the same edge -> no overflow; count stays 4; 8'hEE is the last byte popped.
- Start a stalled read on ch1, assert reset for one cycle, then push on ch1 -> no ready_r; nonempty[1]=1; count 1.
